// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU execution unit.
//   - alu_op_e     : 4-bit operation codes driven by the ALU controller
//   - state_e      : sequencing states of alu_exec_unit
//   - XLEN_DEFAULT : default datapath width
//   - is_shift_op  : identifies the multi-cycle shift operations
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int SHAMT_W      = 5;

    typedef enum logic [3:0] {
        OP_AND    = 4'b0000,
        OP_OR     = 4'b0001,
        OP_ADD    = 4'b0010,
        OP_SUB    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRL    = 4'b0101,
        OP_SRA    = 4'b0111,
        OP_EQ     = 4'b1000,
        OP_XOR    = 4'b1001,
        OP_PASS_B = 4'b1010,
        OP_SLT    = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // True for the three shift codes, which are sequenced one bit per cycle.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: purely combinational single-cycle ALU operations.
// Ports:
//   operation : 4-bit operation code
//   a, b      : XLEN-bit operands
//   y         : XLEN-bit result (0 for shift codes and undefined codes;
//               shifts are sequenced by alu_exec_unit)
module alu_comb
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      operation,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};

    // Operation decode; ADD/SUB wrap modulo 2^XLEN with no carry out.
    always_comb begin
        y = ZERO;
        case (operation)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_ADD:    y = a + b;
            OP_SUB:    y = a - b;
            OP_SLT:    y = ($signed(a) < $signed(b)) ? ONE : ZERO;
            OP_EQ:     y = (a == b) ? ONE : ZERO;
            OP_PASS_B: y = b;
            default:   y = ZERO;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU execution stage with a valid/ready handshake on both
// sides. Logic/arithmetic ops complete in one cycle through alu_comb; shifts
// are performed serially, one bit position per cycle.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake (in_ready only in IDLE)
//   operation, src_a, src_b : operation code and operands (src_b[4:0] = shamt)
//   flush               : synchronous abort of any in-flight operation
//   out_valid / out_ready : result handshake
//   result, zero        : registered result and (result == 0)
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      operation,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};

    state_e               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [XLEN-1:0]      result_q, result_d;
    logic                 zero_q, zero_d;
    logic [XLEN-1:0]      work_q, work_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic [3:0]           shop_q, shop_d;

    logic [XLEN-1:0]      alu_y;
    logic [XLEN-1:0]      stepped;
    logic [SHAMT_W-1:0]   shamt_in;
    logic                 in_is_shift;

    alu_comb #(.XLEN(XLEN)) u_alu_comb (
        .operation (operation),
        .a         (src_a),
        .b         (src_b),
        .y         (alu_y)
    );

    // One-bit shift of the working register in the direction of the held op.
    function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op,
                                                  input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        case (op)
            OP_SLL:  r = {v[XLEN-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[XLEN-1:1]};
            OP_SRA:  r = {v[XLEN-1], v[XLEN-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign shamt_in    = src_b[SHAMT_W-1:0];
    assign in_is_shift = is_shift_op(operation);
    assign stepped     = shift_one(shop_q, work_q);

    // State register plus handshake flags; reset leaves the unit ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Datapath registers: result, zero flag and the serial-shift working set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= ZERO;
            zero_q   <= 1'b1;
            work_q   <= ZERO;
            shamt_q  <= {SHAMT_W{1'b0}};
            shop_q   <= OP_AND;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            work_q   <= work_d;
            shamt_q  <= shamt_d;
            shop_q   <= shop_d;
        end
    end

    // Next-state logic; flush overrides every other input.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (in_is_shift && (shamt_in != {SHAMT_W{1'b0}})) begin
                            state_d = ST_SHIFT;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // The counter holds the remaining steps; the last one lands in DONE.
                    if (shamt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output/datapath logic: handshake flags follow the next state so the
    // outputs come straight from flops; operands are only sampled in IDLE,
    // so later operand changes cannot disturb an in-flight operation.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        result_d    = result_q;
        zero_d      = zero_q;
        work_d      = work_q;
        shamt_d     = shamt_q;
        shop_d      = shop_q;
        if (flush) begin
            shamt_d = {SHAMT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!in_is_shift) begin
                            result_d = alu_y;
                            zero_d   = (alu_y == ZERO);
                        end else if (shamt_in == {SHAMT_W{1'b0}}) begin
                            result_d = src_a;
                            zero_d   = (src_a == ZERO);
                        end else begin
                            work_d  = src_a;
                            shamt_d = shamt_in;
                            shop_d  = operation;
                        end
                    end else begin
                        result_d = result_q;
                    end
                end
                ST_SHIFT: begin
                    work_d  = stepped;
                    shamt_d = shamt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
                    if (shamt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                        result_d = stepped;
                        zero_d   = (stepped == ZERO);
                    end else begin
                        result_d = result_q;
                    end
                end
                ST_DONE: begin
                    result_d = result_q;
                end
                default: begin
                    shamt_d = {SHAMT_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (XLEN = 32).
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_checks;
    int n_fail;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with out_ready=1, scramble operands after the transfer,
    // measure latency, then confirm the result is consumed the next edge.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        operation = op;
        src_a     = a;
        src_b     = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        operation = 4'b0011;
        src_a     = ~a;
        src_b     = 32'h0000_0003;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_res"}, result, exp);
        check_eq({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
        tick();
        check_eq({tag, "_consumed"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        operation = 4'b0000;
        src_a     = 32'd0;
        src_b     = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_result",    result,             32'd0);
        check_eq("rst_zero",      {31'd0, zero},      32'd1);
        rst_n = 1'b1;
        tick();

        do_op("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
        do_op("add_mod",  4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1);
        do_op("sub_zero", 4'b0011, 32'd5, 32'd5, 32'd0, 1);
        do_op("eq_true",  4'b1000, 32'h12, 32'h12, 32'd1, 1);
        do_op("eq_false", 4'b1000, 32'h12, 32'h13, 32'd0, 1);
        do_op("slt_neg",  4'b1100, 32'hFFFF_FFFF, 32'd0, 32'd1, 1);
        do_op("slt_pos",  4'b1100, 32'd0, 32'hFFFF_FFFF, 32'd0, 1);
        do_op("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
        do_op("or",       4'b0001, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1);
        do_op("xor",      4'b1001, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
        do_op("pass_b",   4'b1010, 32'h1111_1111, 32'hCAFE_BABE, 32'hCAFE_BABE, 1);
        do_op("illegal",  4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1);
        do_op("sra4",     4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 5);
        do_op("srl4",     4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 5);
        do_op("sll0",     4'b0100, 32'h0000_0001, 32'd0, 32'h0000_0001, 1);
        do_op("sll31",    4'b0100, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 32);
        do_op("sra1_pos", 4'b0111, 32'h4000_0002, 32'd1, 32'h2000_0001, 2);

        // Stall in DONE for 3 cycles, with a competing in_valid on the consume edge.
        operation = 4'b0010;
        src_a     = 32'd3;
        src_b     = 32'd4;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
            check_eq("stall_res",   result,             32'd7);
            check_eq("stall_ready", {31'd0, in_ready},  32'd0);
            tick();
        end
        src_a     = 32'd9;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("release_state", {30'd0, out_valid, in_ready}, 32'd1);
        tick();
        check_eq("bubble_no_accept", {31'd0, out_valid}, 32'd0);

        // Flush in the third shift cycle while a new op is offered.
        operation = 4'b0101;
        src_a     = 32'hFFFF_0000;
        src_b     = 32'd10;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush     = 1'b1;
        in_valid  = 1'b1;
        operation = 4'b0010;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_state", {30'd0, out_valid, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        check_eq("flush_no_result", seen, 32'd0);

        // Asynchronous reset pulse in the middle of a shift.
        operation = 4'b0111;
        src_a     = 32'h8000_0000;
        src_b     = 32'd10;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_in_ready",  {31'd0, in_ready},  32'd1);
        check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_result",    result,             32'd0);
        check_eq("arst_zero",      {31'd0, zero},      32'd1);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        check_eq("arst_no_result", seen, 32'd0);

        // Unit still works after the reset.
        do_op("post_rst_sub", 4'b0011, 32'd10, 32'd3, 32'd7, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
